// File: rtl/klingon_pkg.sv
// Shared Klingon segment definitions: digit glyph table, blank separator, decoder FSM states.
// The glyph table is the same one the encoder drives; it must stay one-to-one and never contain blank.
package klingon_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] KLINGON_SEG [0:9] = '{
        7'b0001000, 7'b0110000, 7'b1001001, 7'b0110110, 7'b1100011,
        7'b0011101, 7'b1010101, 7'b0101110, 7'b1111001, 7'b0111111
    };

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/klingon_seg_decoder_if.sv
// Segment-in / BCD-word-out bundle of the Klingon segment decoder.
// master = pattern source and word consumer, slave = decoder.
interface klingon_seg_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [4*NUM_DIGITS-1:0] word_data;
    logic                    word_valid;
    logic                    word_ready;
    logic                    digit_err;
    logic                    overrun;
    logic [2:0]              digit_cnt;

    modport master (
        output seg_in, word_ready,
        input  word_data, word_valid, digit_err, overrun, digit_cnt
    );

    modport slave (
        input  seg_in, word_ready,
        output word_data, word_valid, digit_err, overrun, digit_cnt
    );
endinterface

// File: rtl/klingon_seg_lookup.sv
// Purpose: maps a 7-bit Klingon glyph back to its digit; hit=0 for blank or unknown glyphs.
// Latency: combinational.
// Backpressure: none.
module klingon_seg_lookup
    import klingon_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] digit
);

    always_comb begin
        hit   = 1'b0;
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (seg == KLINGON_SEG[i]) begin
                hit   = 1'b1;
                digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/klingon_seg_decoder.sv
// Purpose: debounces Klingon glyphs, decodes them and packs digits MSB-first into BCD words (KLINGON_DEC_STRICT_EN: bad glyph also flushes the partial word).
// Latency: digit accepted STABLE_CYCLES-1 edges after the first registered sample; word_valid rises on the final digit's edge.
// Backpressure: single output register; a word completing while it is full and not taken is dropped with an overrun pulse.
module klingon_seg_decoder
    import klingon_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    klingon_seg_decoder_if.slave bus
);

    localparam int W = 4 * NUM_DIGITS;

    logic [6:0]   s_q;
    logic [3:0]   cnt;
    logic [3:0]   cnt_nxt;
    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic         hit;
    logic [3:0]   digit;
    logic [W-1:0] asm_q;
    logic [W-1:0] asm_shift;
    logic [2:0]   digit_cnt_q;
    logic [3:0]   digit_cnt_inc;
    logic         complete;
    logic         handshake;
    logic [W-1:0] word_q;
    logic         word_valid_q;
    logic         digit_err_q;
    logic         overrun_q;

    klingon_seg_lookup u_lookup (
        .seg   (s_q),
        .hit   (hit),
        .digit (digit)
    );

    // cnt is the run length of s_q including the sample being taken now.
    always_comb begin
        cnt_nxt = cnt;
        if (bus.seg_in == SEG_BLANK) begin
            cnt_nxt = 4'd0;
        end else if (bus.seg_in != s_q) begin
            cnt_nxt = 4'd1;
        end else if (cnt != 4'hF) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= SEG_BLANK;
            cnt <= 4'd0;
        end else begin
            s_q <= bus.seg_in;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARMED: begin
                if (accept)                 state_nxt = LOCKED;
                else if (s_q != SEG_BLANK)  state_nxt = TRACK;
            end
            TRACK: begin
                if (accept)                 state_nxt = LOCKED;
                else if (s_q == SEG_BLANK)  state_nxt = ARMED;
            end
            LOCKED: begin
                if (s_q == SEG_BLANK)       state_nxt = ARMED;
            end
            default:                        state_nxt = ARMED;
        endcase
    end

    // The run reaches its threshold on this edge; with STABLE_CYCLES >= 2 that implies seg_in == s_q.
    always_comb begin
        accept = (state != LOCKED) && (cnt_nxt == 4'(STABLE_CYCLES));
    end

    assign asm_shift     = (asm_q << 4) | W'(digit);
    assign digit_cnt_inc = {1'b0, digit_cnt_q} + 4'd1;
    assign complete      = accept && hit && (digit_cnt_inc == 4'(NUM_DIGITS));
    assign handshake     = word_valid_q && bus.word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q        <= '0;
            digit_cnt_q  <= 3'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            digit_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            digit_err_q <= accept && !hit;
            overrun_q   <= 1'b0;
            if (complete) begin
                asm_q       <= '0;
                digit_cnt_q <= 3'd0;
                if (!word_valid_q || bus.word_ready) begin
                    word_q       <= asm_shift;
                    word_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                if (accept && hit) begin
                    asm_q       <= asm_shift;
                    digit_cnt_q <= digit_cnt_inc[2:0];
                end
`ifdef KLINGON_DEC_STRICT_EN
                else if (accept) begin
                    asm_q       <= '0;
                    digit_cnt_q <= 3'd0;
                end
`endif
                if (handshake) begin
                    word_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.word_data  = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.digit_err  = digit_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_klingon_seg_decoder.sv
// Bench for klingon_seg_decoder: directed scenarios plus random glyph streams against a sample-history model.
module tb_klingon_seg_decoder;
    import klingon_pkg::*;

    localparam int N = 4;
    localparam int S = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    klingon_seg_decoder_if #(.NUM_DIGITS(N)) bus ();

    klingon_seg_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Model: decides acceptance purely from the history of sampled patterns.
    int          m_run = 0;
    bit          m_armed = 1'b1;
    logic [6:0]  m_prev = '0;
    int          m_digs[$];
    logic [15:0] m_data = '0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;
    bit          m_ovr = 1'b0;

    logic [15:0] got[$];
    int          err_seen = 0;
    int          ovr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_armed = 1'b1; m_prev = '0; m_digs.delete();
            m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        end else begin
            bit          hs;
            bit          done;
            int          d;
            logic [15:0] w;
            logic [6:0]  v;
            hs = m_valid && bus.word_ready;
            done = 1'b0; w = '0; m_err = 1'b0; m_ovr = 1'b0;
            v = bus.seg_in;
            if (v == 7'd0) begin
                m_run = 0; m_armed = 1'b1;
            end else begin
                m_run = (v == m_prev) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
                if (m_armed && m_run == S) begin
                    m_armed = 1'b0;
                    d = -1;
                    for (int i = 0; i < 10; i++) if (KLINGON_SEG[i] == v) d = i;
                    if (d >= 0) begin
                        m_digs.push_back(d);
                        if (m_digs.size() == N) begin
                            foreach (m_digs[i]) w = (w << 4) | 16'(m_digs[i]);
                            m_digs.delete();
                            done = 1'b1;
                        end
                    end else begin
                        m_err = 1'b1;
`ifdef KLINGON_DEC_STRICT_EN
                        m_digs.delete();
`endif
                    end
                end
            end
            m_prev = v;
            if (done) begin
                if (!m_valid || hs) begin m_data = w; m_valid = 1'b1; end
                else m_ovr = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("word_valid", 32'(bus.word_valid), 32'(m_valid));
            check("word_data",  32'(bus.word_data),  32'(m_data));
            check("digit_err",  32'(bus.digit_err),  32'(m_err));
            check("overrun",    32'(bus.overrun),    32'(m_ovr));
            check("digit_cnt",  32'(bus.digit_cnt),  32'(m_digs.size()));
            if (bus.word_valid && bus.word_ready) got.push_back(bus.word_data);
            if (bus.digit_err) err_seen++;
            if (bus.overrun) ovr_seen++;
        end
    end

    task automatic cyc(input logic [6:0] s, input logic r);
        bus.seg_in = s;
        bus.word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic digit(input int d, input logic r);
        repeat (S) cyc(KLINGON_SEG[d], r);
        cyc(7'd0, r);
    endtask

    task automatic do_reset();
        bus.seg_in = 7'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int len;
        int k;
        logic [6:0] p;
        reset = 1'b1;
        bus.seg_in = 7'd0;
        bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        started = 1'b1;
        check("reset_valid", 32'(bus.word_valid), 32'd0);
        check("reset_data",  32'(bus.word_data),  32'd0);
        check("reset_cnt",   32'(bus.digit_cnt),  32'd0);

        // Ten digits, three samples each, ready held high.
        for (int d = 0; d < 10; d++) digit(d, 1'b1);
        cyc(7'd0, 1'b1);
        check("seq_words",  32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("seq_word0", 32'(got[0]), 32'h0123);
            check("seq_word1", 32'(got[1]), 32'h4567);
        end
        check("seq_cnt",       32'(bus.digit_cnt), 32'd2);
        check("seq_model_cnt", 32'(m_digs.size()), 32'd2);

        // Mid-word reset discards the partial assembly.
        do_reset();
        check("rst_cnt",   32'(bus.digit_cnt),  32'd0);
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        got.delete();
        digit(9, 1'b1); digit(8, 1'b1); digit(7, 1'b1); digit(6, 1'b1);
        cyc(7'd0, 1'b1);
        check("rst_words", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("rst_word", 32'(got[0]), 32'h9876);

        // Debounce: short hold ignored, long hold accepted once, bad glyph flagged.
        do_reset();
        digit(1, 1'b0);
        cyc(KLINGON_SEG[5], 1'b0); cyc(KLINGON_SEG[5], 1'b0); cyc(7'd0, 1'b0);
        check("short_hold_cnt", 32'(bus.digit_cnt), 32'd1);
        repeat (10) cyc(KLINGON_SEG[5], 1'b0);
        cyc(7'd0, 1'b0);
        check("long_hold_cnt", 32'(bus.digit_cnt), 32'd2);
        err_seen = 0;
        repeat (3) cyc(7'b1111111, 1'b0);
        cyc(7'd0, 1'b0);
        check("bad_err_pulses", 32'(err_seen), 32'd1);
`ifdef KLINGON_DEC_STRICT_EN
        check("bad_cnt", 32'(bus.digit_cnt), 32'd0);
`else
        check("bad_cnt", 32'(bus.digit_cnt), 32'd2);
`endif

        // Overrun: two words complete with ready low.
        do_reset();
        got.delete();
        ovr_seen = 0;
        for (int d = 1; d <= 8; d++) digit(d, 1'b0);
        check("ovr_pulses", 32'(ovr_seen), 32'd1);
        check("ovr_held",   32'(bus.word_data), 32'h1234);
        cyc(7'd0, 1'b1);
        cyc(7'd0, 1'b0);
        check("ovr_hs", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("ovr_hs_word", 32'(got[0]), 32'h1234);
        check("ovr_drained", 32'(bus.word_valid), 32'd0);

        // Completion on the same edge as a handshake.
        do_reset();
        got.delete();
        ovr_seen = 0;
        for (int d = 1; d <= 7; d++) digit(d, 1'b0);
        cyc(KLINGON_SEG[8], 1'b0); cyc(KLINGON_SEG[8], 1'b0); cyc(KLINGON_SEG[8], 1'b1);
        check("coin_valid", 32'(bus.word_valid), 32'd1);
        check("coin_data",  32'(bus.word_data),  32'h5678);
        check("coin_ovr",   32'(ovr_seen), 32'd0);
        cyc(7'd0, 1'b1);
        cyc(7'd0, 1'b0);
        check("coin_words", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("coin_word0", 32'(got[0]), 32'h1234);
            check("coin_word1", 32'(got[1]), 32'h5678);
        end

        // Random glyph streams with random hold lengths, ready and occasional reset.
        for (int it = 0; it < 400; it++) begin
            k = $urandom_range(0, 9);
            if (k < 6)      p = KLINGON_SEG[$urandom_range(0, 9)];
            else if (k < 8) p = 7'd0;
            else            p = 7'($urandom_range(1, 127));
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) cyc(p, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 79) == 0) do_reset();
        end
        cyc(7'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/klingon_seg_decoder.md
# klingon_seg_decoder

Inverse of the Klingon digit encoder. Samples a 7-segment pattern bus and debounces it. Each stable pattern is decoded back to its digit 0-9. Decoded digits are packed MSB-first into a multi-digit BCD word, which is handed downstream over a valid/ready handshake. It sits between a segment-pattern source (panel, loopback of the encoder output, or bench) and any consumer of numeric words.

## Interface
- NUM_DIGITS, 4: digits per output word (1-8).
- STABLE_CYCLES, 3: consecutive identical samples required to accept a pattern (2-15).
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  raw segment pattern; 7'b0000000 is blank (separator).
- word_data  output  4*NUM_DIGITS  packed BCD; first accepted digit in the top nibble.
- word_valid  output  1  word_data holds a complete word.
- word_ready  input  1  consumer accepts word this cycle.
- digit_err  output  1  one-cycle pulse: stable non-blank pattern not in the Klingon table.
- overrun  output  1  one-cycle pulse: completed word dropped because the output register was full.
- digit_cnt  output  3  digits currently in the assembly register.

## Operation
- seg_in is registered once into s_q. Stability counter cnt: cleared when s_q changes or is blank; increments (saturating) otherwise.
- FSM states:
  - ARMED: waits for a non-blank s_q, then goes to TRACK.
  - TRACK: if s_q changes to another non-blank value, cnt restarts and the state stays TRACK. If s_q goes blank, return to ARMED. When cnt reaches STABLE_CYCLES, accept and go to LOCKED.
  - LOCKED: holds until s_q is blank, then returns to ARMED.
- A held pattern is accepted exactly once. Repeating a digit requires a blank of at least one sample between occurrences.
- Accept:
  - Pattern in the table: the digit shifts into the assembly register and digit_cnt increments.
  - Pattern not in the table: digit_err pulses and the digit is discarded.
- When digit_cnt reaches NUM_DIGITS, the assembly moves to the output register, word_valid is set, and digit_cnt returns to 0 on the same edge.
- Output register:
  - word_valid && word_ready clears word_valid.
  - Completion while word_valid=1 and word_ready=0: the new word is dropped, overrun pulses, and the old word is kept.
  - Completion on the same edge as word_valid && word_ready: the new word loads and word_valid stays 1.
- Reset values: word_data=0, word_valid=0, digit_err=0, overrun=0, digit_cnt=0, FSM=ARMED, s_q=0, cnt=0.
- Reset mid-word discards the partial assembly.

## Timing
- seg_in changes before edge E and is held. s_q updates at E. Acceptance (digit_cnt update or digit_err pulse) occurs at edge E+STABLE_CYCLES-1.
- word_valid rises on the same edge that the final digit is accepted. There is no additional latency.
- word_data is stable while word_valid=1 and word_ready=0.
- digit_err and overrun are high for exactly one cycle.

## Configuration
- KLINGON_DEC_STRICT_EN defined: an invalid pattern also clears the assembly register (digit_cnt returns to 0), discarding the partial word.
- KLINGON_DEC_STRICT_EN undefined: an invalid pattern only discards that digit; the partial word is kept.

## Structure
- The shared package klingon_pkg holds:
  - KLINGON_SEG[0:9] (7-bit patterns, the same table the encoder uses);
  - SEG_BLANK;
  - the FSM state typedef (ARMED/TRACK/LOCKED).
- Sub-module klingon_seg_lookup is combinational. It maps 7-bit pattern to {hit, digit[3:0]} and is the exact inverse of KLINGON_SEG.

## Test plan
- Digits 0-9 are each presented as KLINGON_SEG[d] for 3 cycles, separated by 1 blank cycle (defaults). Required result: words 16'h0123, 16'h4567 with word_ready=1; digit_cnt=2 holding 8,9.
- KLINGON_SEG[5] held for 2 cycles then blank: no accept, digit_cnt unchanged. Held for 10 cycles: exactly one accept.
- Pattern 7'b1111111 (not in table) held for 3 cycles: digit_err pulses once. Non-strict build keeps digit_cnt; strict build clears digit_cnt to 0.
- word_ready=0 while two words complete: first word (16'h1234) is held, overrun pulses on the second completion. Raising word_ready then gives exactly one handshake with 16'h1234.
- Completion edge coincides with word_valid && word_ready: the new word loads, word_valid stays 1, and no overrun occurs.
- reset asserted after 2 digits for 1 cycle: all outputs return to reset values, and the next 4 digits form a fresh word.
